// File: rtl/mem_arb_pkg.sv
// Shared definitions for the memory port arbiter: cpustate encodings, FSM states,
// requester indices and small helpers used by the arbiter and its picker.
package mem_arb_pkg;

  localparam logic [1:0] CS_IDLE  = 2'b00;
  localparam logic [1:0] CS_IN    = 2'b01;
  localparam logic [1:0] CS_CHECK = 2'b10;
  localparam logic [1:0] CS_RUN   = 2'b11;

  localparam int NPORT = 3;

  localparam logic [1:0] P_CPU = 2'd0;
  localparam logic [1:0] P_CHK = 2'd1;
  localparam logic [1:0] P_LD  = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_RDATA = 2'd2
  } arb_state_e;

  // Bit positions follow the port indices: {ld, chk, cpu}.
  function automatic logic [NPORT-1:0] elig_mask(input logic [1:0] cs);
    logic [NPORT-1:0] m;
    case (cs)
      CS_IN:    m = 3'b100;
      CS_CHECK: m = 3'b010;
      CS_RUN:   m = 3'b011;
      default:  m = 3'b000;
    endcase
    return m;
  endfunction

  function automatic logic [1:0] onehot_to_idx(input logic [NPORT-1:0] oh);
    logic [1:0] idx;
    if (oh[P_LD])       idx = P_LD;
    else if (oh[P_CHK]) idx = P_CHK;
    else                idx = P_CPU;
    return idx;
  endfunction

  // Cyclic successor in the order cpu -> chk -> ld -> cpu.
  function automatic logic [1:0] rr_next(input logic [1:0] p);
    return (p == P_LD) ? P_CPU : p + 2'd1;
  endfunction

endpackage

// File: rtl/rr_pick3.sv
// Combinational three-way picker producing a one-hot winner. Rotating priority after
// the last-granted index when MEM_ARB_RR_EN is defined, fixed cpu > chk > ld otherwise.
module rr_pick3
  import mem_arb_pkg::*;
(
  input  logic [NPORT-1:0] req,
  input  logic [1:0]       last,
  output logic [NPORT-1:0] win
);

`ifdef MEM_ARB_RR_EN
  logic [1:0] first_idx;
  logic [1:0] second_idx;
  logic [1:0] third_idx;

  always_comb begin
    first_idx  = rr_next(last);
    second_idx = rr_next(first_idx);
    third_idx  = rr_next(second_idx);
    win        = '0;
    if (req[first_idx])       win[first_idx]  = 1'b1;
    else if (req[second_idx]) win[second_idx] = 1'b1;
    else if (req[third_idx])  win[third_idx]  = 1'b1;
  end
`else
  // Lower index wins: a port is granted only if no lower-indexed port requests.
  for (genvar gi = 0; gi < NPORT; gi++) begin : g_fixed
    localparam logic [NPORT-1:0] HIGHER = (3'b1 << gi) - 3'b1;
    assign win[gi] = req[gi] & ~|(req & HIGHER);
  end

  logic unused_last;
  assign unused_last = ^last;
`endif

endmodule

// File: rtl/mem_port_arbiter.sv
// Serialises cpu, loader and checker accesses onto the single synchronous memory port.
// MEM_ARB_RR_EN selects rotating priority; undefined gives fixed cpu > chk > ld.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int AW = 16,
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [1:0]    cpustate,
  input  logic          cpu_req,
  input  logic          ld_req,
  input  logic          chk_req,
  input  logic          cpu_we,
  input  logic          ld_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [AW-1:0] ld_addr,
  input  logic [AW-1:0] chk_addr,
  input  logic [DW-1:0] cpu_wdata,
  input  logic [DW-1:0] ld_wdata,
  output logic          cpu_gnt,
  output logic          ld_gnt,
  output logic          chk_gnt,
  output logic          cpu_rvalid,
  output logic          chk_rvalid,
  output logic          ld_rvalid,
  output logic [DW-1:0] rdata,
  output logic          mem_rd,
  output logic          mem_wr,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          busy
);

  arb_state_e state_reg, state_next;

  logic [1:0]       id_reg;
  logic             we_reg;
  logic [AW-1:0]    addr_reg;
  logic [DW-1:0]    wdata_reg;
  logic [DW-1:0]    rdata_reg;

  logic [NPORT-1:0] req_vec;
  logic [NPORT-1:0] win_vec;
  logic [1:0]       win_idx;
  logic [1:0]       last_idx;
  logic             pick;

  logic             win_we;
  logic [AW-1:0]    win_addr;
  logic [DW-1:0]    win_wdata;

  logic [NPORT-1:0] gnt_vec;
  logic [NPORT-1:0] rvalid_vec;

  assign req_vec = {ld_req, chk_req, cpu_req} & elig_mask(cpustate);
  assign pick    = (state_reg == ST_IDLE) && (|req_vec);
  assign win_idx = onehot_to_idx(win_vec);

`ifdef MEM_ARB_RR_EN
  logic [1:0] last_reg;

  assign last_idx = last_reg;
`else
  assign last_idx = P_LD;
`endif

  rr_pick3 u_pick (
    .req  (req_vec),
    .last (last_idx),
    .win  (win_vec)
  );

  // Command fields of the winner; the checker port is read-only.
  always_comb begin
    win_we    = 1'b0;
    win_addr  = cpu_addr;
    win_wdata = cpu_wdata;
    case (win_idx)
      P_CPU: begin
        win_we    = cpu_we;
        win_addr  = cpu_addr;
        win_wdata = cpu_wdata;
      end
      P_CHK: begin
        win_we    = 1'b0;
        win_addr  = chk_addr;
        win_wdata = '0;
      end
      P_LD: begin
        win_we    = ld_we;
        win_addr  = ld_addr;
        win_wdata = ld_wdata;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= ST_IDLE;
      id_reg    <= P_CPU;
      we_reg    <= 1'b0;
      addr_reg  <= '0;
      wdata_reg <= '0;
      rdata_reg <= '0;
`ifdef MEM_ARB_RR_EN
      last_reg  <= P_LD;
`endif
    end else begin
      state_reg <= state_next;
      if (pick) begin
        id_reg    <= win_idx;
        we_reg    <= win_we;
        addr_reg  <= win_addr;
        wdata_reg <= win_wdata;
      end
      if (state_reg == ST_RDATA) begin
        rdata_reg <= mem_rdata;
      end
`ifdef MEM_ARB_RR_EN
      if (state_reg == ST_ISSUE) begin
        last_reg <= id_reg;
      end
`endif
    end
  end

  always_comb begin
    state_next = state_reg;
    gnt_vec    = '0;
    rvalid_vec = '0;
    mem_rd     = 1'b0;
    mem_wr     = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (pick) state_next = ST_ISSUE;
      end
      ST_ISSUE: begin
        gnt_vec    = 3'b001 << id_reg;
        mem_wr     = we_reg;
        mem_rd     = ~we_reg;
        state_next = we_reg ? ST_IDLE : ST_RDATA;
      end
      ST_RDATA: begin
        rvalid_vec = 3'b001 << id_reg;
        state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
    // Reset kills the access in flight, including a read's rvalid.
    if (rst) begin
      gnt_vec    = '0;
      rvalid_vec = '0;
      mem_rd     = 1'b0;
      mem_wr     = 1'b0;
    end
  end

  assign cpu_gnt    = gnt_vec[P_CPU];
  assign chk_gnt    = gnt_vec[P_CHK];
  assign ld_gnt     = gnt_vec[P_LD];
  assign cpu_rvalid = rvalid_vec[P_CPU];
  assign chk_rvalid = rvalid_vec[P_CHK];
  assign ld_rvalid  = rvalid_vec[P_LD];

  // The memory's output register is forwarded in the RDATA cycle and held afterwards.
  assign rdata     = (|rvalid_vec) ? mem_rdata : rdata_reg;
  assign mem_addr  = addr_reg;
  assign mem_wdata = wdata_reg;
  assign busy      = (state_reg != ST_IDLE);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed testbench for mem_port_arbiter with a small synchronous memory model;
// expected values are hand-computed per cycle for both priority builds.
module tb_mem_port_arbiter;

  localparam int AW = 16;
  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic [1:0]    cpustate;
  logic          cpu_req, ld_req, chk_req;
  logic          cpu_we, ld_we;
  logic [AW-1:0] cpu_addr, ld_addr, chk_addr;
  logic [DW-1:0] cpu_wdata, ld_wdata;
  logic          cpu_gnt, ld_gnt, chk_gnt;
  logic          cpu_rvalid, chk_rvalid, ld_rvalid;
  logic [DW-1:0] rdata;
  logic          mem_rd, mem_wr;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  logic          busy;

  logic [2:0]    gnt_v;
  logic [2:0]    rv_v;
  logic [7:0]    mem [0:255];

  int n_checks = 0;
  int n_fail   = 0;
  int exp_g [9];
  int exp_r [9];
  int exp_d [9];
  int second_port;
  int second_data;

  assign gnt_v = {ld_gnt, chk_gnt, cpu_gnt};
  assign rv_v  = {ld_rvalid, chk_rvalid, cpu_rvalid};

  always #5 clk = ~clk;

  mem_port_arbiter #(.AW(AW), .DW(DW)) dut (
    .clk        (clk),
    .rst        (rst),
    .cpustate   (cpustate),
    .cpu_req    (cpu_req),
    .ld_req     (ld_req),
    .chk_req    (chk_req),
    .cpu_we     (cpu_we),
    .ld_we      (ld_we),
    .cpu_addr   (cpu_addr),
    .ld_addr    (ld_addr),
    .chk_addr   (chk_addr),
    .cpu_wdata  (cpu_wdata),
    .ld_wdata   (ld_wdata),
    .cpu_gnt    (cpu_gnt),
    .ld_gnt     (ld_gnt),
    .chk_gnt    (chk_gnt),
    .cpu_rvalid (cpu_rvalid),
    .chk_rvalid (chk_rvalid),
    .ld_rvalid  (ld_rvalid),
    .rdata      (rdata),
    .mem_rd     (mem_rd),
    .mem_wr     (mem_wr),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata),
    .busy       (busy)
  );

  // Synchronous memory: read data appears the cycle after mem_rd.
  always @(posedge clk) begin
    if (rst) begin
      mem[8'h20] <= 8'h3C;
      mem[8'h21] <= 8'h5A;
    end else begin
      if (mem_wr) mem[mem_addr[7:0]] <= mem_wdata;
      if (mem_rd) mem_rdata <= mem[mem_addr[7:0]];
    end
  end

  always @(negedge clk) begin
    if (!rst && (|gnt_v))
      $display("txn t=%0t gnt=%b rd=%0d wr=%0d addr=%h wdata=%h", $time, gnt_v, mem_rd, mem_wr, mem_addr, mem_wdata);
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst       = 1'b1;
    cpustate  = 2'b00;
    cpu_req   = 1'b1;
    ld_req    = 1'b1;
    chk_req   = 1'b1;
    cpu_we    = 1'b0;
    ld_we     = 1'b0;
    cpu_addr  = '0;
    ld_addr   = '0;
    chk_addr  = '0;
    cpu_wdata = '0;
    ld_wdata  = '0;

`ifdef MEM_ARB_RR_EN
    second_port = 2;
    second_data = 'h5A;
`else
    second_port = 1;
    second_data = 'h3C;
`endif

    // Reset with all requests high, then IDLE cpustate: nothing is granted.
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      check_eq("rst_gnt", 32'(gnt_v), 0);
      check_eq("rst_rvalid", 32'(rv_v), 0);
      check_eq("rst_busy", 32'(busy), 0);
      check_eq("rst_cmd", 32'({mem_rd, mem_wr}), 0);
      if (c == 0) begin
        check_eq("rst_mem_addr", 32'(mem_addr), 0);
        check_eq("rst_mem_wdata", 32'(mem_wdata), 0);
        check_eq("rst_rdata", 32'(rdata), 0);
      end
    end

    // IN state: loader write wins, cpu ignored.
    next_cycle();
    chk_req  = 1'b0;
    cpu_we   = 1'b1;
    cpu_addr = 16'h0099;
    ld_we    = 1'b1;
    ld_addr  = 16'h0010;
    ld_wdata = 8'hA5;
    cpustate = 2'b01;
    @(negedge clk);
    check_eq("in_n_gnt", 32'(gnt_v), 0);
    check_eq("in_n_busy", 32'(busy), 0);
    @(negedge clk);
    check_eq("in_gnt", 32'(gnt_v), 4);
    check_eq("in_cmd", 32'({mem_rd, mem_wr}), 1);
    check_eq("in_addr", 32'(mem_addr), 'h10);
    check_eq("in_wdata", 32'(mem_wdata), 'hA5);
    check_eq("in_busy", 32'(busy), 1);
    next_cycle();
    ld_req = 1'b0;
    ld_we  = 1'b0;
    @(negedge clk);
    check_eq("in_after_busy", 32'(busy), 0);
    check_eq("in_after_rvalid", 32'(rv_v), 0);
    @(negedge clk);
    check_eq("in_cpu_masked", 32'(gnt_v), 0);
    check_eq("in_idle_busy", 32'(busy), 0);

    // RUN state: cpu read of preloaded 0x3C at 0x0020.
    next_cycle();
    cpustate = 2'b11;
    cpu_we   = 1'b0;
    cpu_addr = 16'h0020;
    @(negedge clk);
    check_eq("rd_n_gnt", 32'(gnt_v), 0);
    @(negedge clk);
    check_eq("rd_gnt", 32'(gnt_v), 1);
    check_eq("rd_cmd", 32'({mem_rd, mem_wr}), 2);
    check_eq("rd_addr", 32'(mem_addr), 'h20);
    next_cycle();
    cpu_req = 1'b0;
    @(negedge clk);
    check_eq("rd_rvalid", 32'(rv_v), 1);
    check_eq("rd_data", 32'(rdata), 'h3C);
    check_eq("rd_busy", 32'(busy), 1);
    @(negedge clk);
    check_eq("rd_done_rvalid", 32'(rv_v), 0);
    check_eq("rd_hold_data", 32'(rdata), 'h3C);
    check_eq("rd_done_busy", 32'(busy), 0);

    // Reset pulse returns the pointer to ld, then cpu and chk contend in RUN.
    next_cycle();
    rst = 1'b1;
    next_cycle();
    rst      = 1'b0;
    cpu_req  = 1'b1;
    chk_req  = 1'b1;
    ld_req   = 1'b1;
    ld_we    = 1'b1;
    cpu_addr = 16'h0020;
    chk_addr = 16'h0021;
    for (int c = 0; c < 9; c++) begin
      exp_g[c] = 0;
      exp_r[c] = 0;
      exp_d[c] = 0;
    end
    exp_g[1] = 1;           exp_r[2] = 1;           exp_d[2] = 'h3C;
    exp_g[4] = second_port; exp_r[5] = second_port; exp_d[5] = second_data;
    exp_g[7] = 1;           exp_r[8] = 1;           exp_d[8] = 'h3C;
    for (int c = 0; c < 9; c++) begin
      if (c > 0) next_cycle();
      if (c == 8) begin
        cpu_req = 1'b0;
        chk_req = 1'b0;
        ld_req  = 1'b0;
        ld_we   = 1'b0;
      end
      @(negedge clk);
      check_eq($sformatf("cont_gnt_c%0d", c), 32'(gnt_v), exp_g[c]);
      check_eq($sformatf("cont_rvalid_c%0d", c), 32'(rv_v), exp_r[c]);
      if (exp_r[c] != 0) check_eq($sformatf("cont_rdata_c%0d", c), 32'(rdata), exp_d[c]);
    end

    // cpu read in flight while cpustate moves RUN -> CHECK.
    next_cycle();
    cpu_req  = 1'b1;
    cpu_addr = 16'h0021;
    cpustate = 2'b11;
    @(negedge clk);
    check_eq("mc_n_gnt", 32'(gnt_v), 0);
    next_cycle();
    cpustate = 2'b10;
    chk_req  = 1'b1;
    chk_addr = 16'h0020;
    @(negedge clk);
    check_eq("mc_cpu_gnt", 32'(gnt_v), 1);
    check_eq("mc_cmd", 32'({mem_rd, mem_wr}), 2);
    @(negedge clk);
    check_eq("mc_cpu_rvalid", 32'(rv_v), 1);
    check_eq("mc_cpu_rdata", 32'(rdata), 'h5A);
    @(negedge clk);
    check_eq("mc_idle_gnt", 32'(gnt_v), 0);
    @(negedge clk);
    check_eq("mc_chk_gnt", 32'(gnt_v), 2);
    check_eq("mc_chk_addr", 32'(mem_addr), 'h20);
    next_cycle();
    chk_req = 1'b0;
    cpu_req = 1'b0;
    @(negedge clk);
    check_eq("mc_chk_rvalid", 32'(rv_v), 2);
    check_eq("mc_chk_rdata", 32'(rdata), 'h3C);

    // Reset asserted during RDATA suppresses rvalid and clears everything.
    next_cycle();
    cpustate = 2'b11;
    cpu_req  = 1'b1;
    cpu_addr = 16'h0021;
    @(negedge clk);
    check_eq("rr_n_gnt", 32'(gnt_v), 0);
    @(negedge clk);
    check_eq("rr_gnt", 32'(gnt_v), 1);
    next_cycle();
    cpu_req = 1'b0;
    rst     = 1'b1;
    @(negedge clk);
    check_eq("rr_no_rvalid", 32'(rv_v), 0);
    next_cycle();
    rst = 1'b0;
    @(negedge clk);
    check_eq("rr_busy", 32'(busy), 0);
    check_eq("rr_gnt_after", 32'(gnt_v), 0);
    check_eq("rr_rvalid_after", 32'(rv_v), 0);
    check_eq("rr_cmd_after", 32'({mem_rd, mem_wr}), 0);
    check_eq("rr_mem_addr", 32'(mem_addr), 0);
    check_eq("rr_mem_wdata", 32'(mem_wdata), 0);
    check_eq("rr_rdata", 32'(rdata), 0);
    @(negedge clk);
    check_eq("rr_idle_busy", 32'(busy), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
